// File: rtl/dram_arb_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states and requester ids.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_WB  = 1'b1;

endpackage

// File: rtl/dram_arb_rr.sv
// Two-way grant logic. Round-robin on ties by default; DRAM_ARB_FIXED_PRIO_EN selects fixed Wishbone priority.
// Combinational grant; the last-grant pointer updates only when the grant is taken.
module dram_arb_rr
  import dram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_cpu,
  input  logic req_wb,
  input  logic take,
  output logic gnt_vld,
  output logic gnt_id
);

  assign gnt_vld = req_cpu | req_wb;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  assign gnt_id = req_wb ? REQ_WB : REQ_CPU;
`else
  logic last_q, last_d;

  always_comb begin
    gnt_id = req_wb ? REQ_WB : REQ_CPU;
    if (req_cpu && req_wb) begin
      gnt_id = ~last_q;
    end
    last_d = take ? gnt_id : last_q;
  end

  // Pointer starts at Wishbone so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_WB;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data SRAM between the CPU data port and a Wishbone slave window (IDLE/ACCESS/RESP).
// Hit: RAM pins one cycle after grant, ack the cycle after; miss: err/ack one cycle after grant. Tie rule set by DRAM_ARB_FIXED_PRIO_EN.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR            = 32'h3000_4000,
  parameter int          RAM_ADDR_WIDTH_WORDS = 9
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            cpu_stb,
  input  logic [3:0]                      cpu_we,
  input  logic [31:0]                     cpu_addr,
  input  logic [31:0]                     cpu_wdata,
  output logic [31:0]                     cpu_rdata,
  output logic                            cpu_ack,
  output logic                            cpu_err,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  output logic                            ram_clk0,
  output logic                            ram_csb0,
  output logic                            ram_web0,
  output logic [3:0]                      ram_wmask0,
  output logic [RAM_ADDR_WIDTH_WORDS-1:0] ram_addr0,
  output logic [31:0]                     ram_din0,
  input  logic [31:0]                     ram_dout0
);

  localparam int          AW        = RAM_ADDR_WIDTH_WORDS;
  localparam logic [32:0] WIN_BYTES = 33'd1 << (AW + 2);

  state_e          state_q, state_d;
  logic            gnt_id_q, gnt_id_d;
  logic            wr_q, wr_d;
  logic            miss_q, miss_d;
  logic            abort_q, abort_d;
  logic            ram_csb0_q, ram_csb0_d;
  logic            ram_web0_q, ram_web0_d;
  logic [3:0]      ram_wmask0_q, ram_wmask0_d;
  logic [AW-1:0]   ram_addr0_q, ram_addr0_d;
  logic [31:0]     ram_din0_q, ram_din0_d;

  logic            gnt_vld, gnt_id, take;
  logic [31:0]     sel_addr, sel_wdata, sel_off;
  logic [3:0]      sel_mask;
  logic            sel_wr, sel_hit;

  dram_arb_rr u_rr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req_cpu (cpu_stb),
    .req_wb  (wbs_stb_i & wbs_cyc_i),
    .take    (take),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign take      = (state_q == ST_IDLE) && gnt_vld;
  assign sel_addr  = (gnt_id == REQ_CPU) ? cpu_addr  : wbs_adr_i;
  assign sel_wdata = (gnt_id == REQ_CPU) ? cpu_wdata : wbs_dat_i;
  assign sel_mask  = (gnt_id == REQ_CPU) ? cpu_we    : wbs_sel_i;
  assign sel_wr    = (gnt_id == REQ_CPU) ? (|cpu_we) : wbs_we_i;
  // Addresses below the base wrap to large offsets and fall outside the window.
  assign sel_off   = sel_addr - BASE_ADDR;
  assign sel_hit   = {1'b0, sel_off} < WIN_BYTES;

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    wr_d         = wr_q;
    miss_d       = miss_q;
    abort_d      = abort_q;
    ram_csb0_d   = 1'b1;
    ram_web0_d   = 1'b1;
    ram_wmask0_d = '0;
    ram_addr0_d  = ram_addr0_q;
    ram_din0_d   = ram_din0_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          gnt_id_d = gnt_id;
          wr_d     = sel_wr;
          miss_d   = ~sel_hit;
          abort_d  = 1'b0;
          if (sel_hit) begin
            state_d      = ST_ACCESS;
            ram_csb0_d   = 1'b0;
            ram_web0_d   = ~sel_wr;
            ram_wmask0_d = sel_wr ? sel_mask : 4'b0000;
            ram_addr0_d  = sel_addr[AW+1:2];
            ram_din0_d   = sel_wdata;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (gnt_id_q == REQ_WB && !wbs_cyc_i) begin
          abort_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      gnt_id_q     <= REQ_CPU;
      wr_q         <= 1'b0;
      miss_q       <= 1'b0;
      abort_q      <= 1'b0;
      ram_csb0_q   <= 1'b1;
      ram_web0_q   <= 1'b1;
      ram_wmask0_q <= '0;
      ram_addr0_q  <= '0;
      ram_din0_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      wr_q         <= wr_d;
      miss_q       <= miss_d;
      abort_q      <= abort_d;
      ram_csb0_q   <= ram_csb0_d;
      ram_web0_q   <= ram_web0_d;
      ram_wmask0_q <= ram_wmask0_d;
      ram_addr0_q  <= ram_addr0_d;
      ram_din0_q   <= ram_din0_d;
    end
  end

  logic resp, resp_cpu, resp_wb, rd_hit;
  assign resp     = (state_q == ST_RESP);
  assign resp_cpu = resp && (gnt_id_q == REQ_CPU);
  assign resp_wb  = resp && (gnt_id_q == REQ_WB);
  assign rd_hit   = !miss_q && !wr_q;

  assign cpu_ack   = resp_cpu && !miss_q;
  assign cpu_err   = resp_cpu && miss_q;
  assign cpu_rdata = (resp_cpu && rd_hit) ? ram_dout0 : 32'h0;
  // A master that dropped cyc after grant gets no ack; the RAM access itself is not cancelled.
  assign wbs_ack_o = resp_wb && wbs_cyc_i && !abort_q;
  assign wbs_dat_o = (resp_wb && rd_hit) ? ram_dout0 : 32'h0;

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = ram_csb0_q;
  assign ram_web0   = ram_web0_q;
  assign ram_wmask0 = ram_wmask0_q;
  assign ram_addr0  = ram_addr0_q;
  assign ram_din0   = ram_din0_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: behavioural SRAM, per-requester response scoreboards and a RAM-pin access scoreboard.
module tb_dram_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cpu_stb = 1'b0;
  logic [3:0]  cpu_we = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o;
  logic        wbs_ack_o;
  logic        ram_clk0, ram_csb0, ram_web0;
  logic [3:0]  ram_wmask0;
  logic [8:0]  ram_addr0;
  logic [31:0] ram_din0;
  logic [31:0] ram_dout0 = '0;

  always #5 wb_clk_i = ~wb_clk_i;

  dram_arbiter dut (
    .wb_clk_i  (wb_clk_i),  .wb_rst_i  (wb_rst_i),
    .cpu_stb   (cpu_stb),   .cpu_we    (cpu_we),    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata), .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .wbs_stb_i (wbs_stb_i), .wbs_cyc_i (wbs_cyc_i), .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i), .wbs_adr_i (wbs_adr_i), .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o), .wbs_dat_o (wbs_dat_o),
    .ram_clk0  (ram_clk0),  .ram_csb0  (ram_csb0),  .ram_web0  (ram_web0),
    .ram_wmask0(ram_wmask0),.ram_addr0 (ram_addr0), .ram_din0  (ram_din0),
    .ram_dout0 (ram_dout0)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [31:0] mem [0:511];
  always @(posedge ram_clk0) begin
    if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask0[b]) mem[ram_addr0][8*b +: 8] <= ram_din0[8*b +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  typedef struct { logic err; logic [31:0] rdata; } cpu_exp_t;
  typedef struct { logic [8:0] addr; logic web; logic [3:0] wmask; logic [31:0] din; } ram_exp_t;

  cpu_exp_t    cpu_exp_q[$];
  logic [31:0] wb_exp_q[$];
  ram_exp_t    ram_exp_q[$];
  int          order_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        ram_chk_en = 1'b0;
  logic        prev_cpu_resp = 1'b0, prev_wb_ack = 1'b0;
  cpu_exp_t    ce;
  ram_exp_t    re;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ram_push(input int a, input logic web, input logic [3:0] m, input logic [31:0] d);
    ram_exp_q.push_back('{addr: 9'(a), web: web, wmask: m, din: d});
  endtask

  // Drivers start at posedge+1; lat counts negedges after the sampling edge (0 = do not check).
  task automatic cpu_go(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input int lat);
    int n;
    logic got;
    cpu_exp_q.push_back('{err: exp_err, rdata: exp_rd});
    cpu_stb = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge wb_clk_i);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge wb_clk_i);
      n++;
      got = cpu_ack | cpu_err;
    end
    check_eq("cpu_done", 32'(got), 32'd1);
    if (lat > 0) check_eq("cpu_latency", 32'(n), 32'(lat));
    @(posedge wb_clk_i); #1;
    cpu_stb = 1'b0; cpu_we = '0;
  endtask

  task automatic wb_go(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [31:0] exp_rd, input int lat);
    int n;
    logic got;
    wb_exp_q.push_back(exp_rd);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = dat;
    @(posedge wb_clk_i);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge wb_clk_i);
      n++;
      got = wbs_ack_o;
    end
    check_eq("wb_done", 32'(got), 32'd1);
    if (lat > 0) check_eq("wb_latency", 32'(n), 32'(lat));
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  // Response and RAM-pin monitor.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (cpu_ack || cpu_err) begin
        check_eq("cpu_resp_single", 32'(prev_cpu_resp), 32'd0);
        check_eq("cpu_resp_expected", 32'(cpu_exp_q.size() != 0), 32'd1);
        if (cpu_exp_q.size() != 0) begin
          ce = cpu_exp_q.pop_front();
          check_eq("cpu_err", 32'(cpu_err), 32'(ce.err));
          check_eq("cpu_ack", 32'(cpu_ack), 32'(!ce.err));
          check_eq("cpu_rdata", cpu_rdata, ce.rdata);
        end
        order_q.push_back(0);
      end
      if (wbs_ack_o) begin
        check_eq("wb_ack_single", 32'(prev_wb_ack), 32'd0);
        check_eq("wb_resp_expected", 32'(wb_exp_q.size() != 0), 32'd1);
        if (wb_exp_q.size() != 0) check_eq("wb_dat", wbs_dat_o, wb_exp_q.pop_front());
        order_q.push_back(1);
      end
      if (!ram_csb0 && ram_chk_en) begin
        check_eq("ram_access_expected", 32'(ram_exp_q.size() != 0), 32'd1);
        if (ram_exp_q.size() != 0) begin
          re = ram_exp_q.pop_front();
          check_eq("ram_addr", 32'(ram_addr0), 32'(re.addr));
          check_eq("ram_web", 32'(ram_web0), 32'(re.web));
          check_eq("ram_wmask", 32'(ram_wmask0), 32'(re.wmask));
          if (!re.web) check_eq("ram_din", ram_din0, re.din);
        end
      end
    end
    prev_cpu_resp = cpu_ack | cpu_err;
    prev_wb_ack   = wbs_ack_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    int exp_order[4];
`ifdef DRAM_ARB_FIXED_PRIO_EN
    exp_order = '{1, 1, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 512; i++) mem[i] = 32'h5500_0000 + 32'(i);
    mem[2]  = 32'hAAAA_AAAA;
    mem[4]  = 32'hDEAD_BEEF;
    mem[10] = 32'h0A0A_000A;
    mem[11] = 32'h0B0B_000B;
    mem[12] = 32'h0C0C_000C;
    mem[13] = 32'h0D0D_000D;

    repeat (3) @(posedge wb_clk_i);
    #1;
    check_eq("rst_csb", 32'(ram_csb0), 32'd1);
    check_eq("rst_web", 32'(ram_web0), 32'd1);
    check_eq("rst_wmask", 32'(ram_wmask0), 32'd0);
    check_eq("rst_addr", 32'(ram_addr0), 32'd0);
    check_eq("rst_din", ram_din0, 32'd0);
    check_eq("rst_acks", 32'({cpu_ack, cpu_err, wbs_ack_o}), 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_wb_dat", wbs_dat_o, 32'd0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    ram_chk_en = 1'b1;

    ram_push(4, 1'b1, 4'b0000, 32'h0);
    cpu_go(4'b0000, 32'h3000_4010, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    ram_push(2, 1'b0, 4'b0011, 32'h1234_5678);
    wb_go(1'b1, 4'b0011, 32'h3000_4008, 32'h1234_5678, 32'h0, 2);
    ram_push(2, 1'b1, 4'b0000, 32'h0);
    cpu_go(4'b0000, 32'h3000_4008, 32'h0, 1'b0, 32'hAAAA_5678, 2);
    ram_push(4, 1'b0, 4'b1000, 32'h1122_3344);
    cpu_go(4'b1000, 32'h3000_4010, 32'h1122_3344, 1'b0, 32'h0, 2);
    ram_push(4, 1'b1, 4'b0000, 32'h0);
    wb_go(1'b0, 4'hF, 32'h3000_4010, 32'h0, 32'h11AD_BEEF, 2);
    ram_push(511, 1'b0, 4'hF, 32'hCAFE_F00D);
    cpu_go(4'hF, 32'h3000_47FC, 32'hCAFE_F00D, 1'b0, 32'h0, 2);
    ram_push(511, 1'b1, 4'b0000, 32'h0);
    wb_go(1'b0, 4'hF, 32'h3000_47FC, 32'h0, 32'hCAFE_F00D, 2);

    // Out-of-window: one past the end, far below, just below base, and a Wishbone write miss.
    cpu_go(4'b0000, 32'h3000_4800, 32'h0, 1'b1, 32'h0, 1);
    cpu_go(4'b0000, 32'h3000_0000, 32'h0, 1'b1, 32'h0, 1);
    cpu_go(4'hF, 32'h3000_3FFC, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    wb_go(1'b1, 4'hF, 32'h3000_4800, 32'hFFFF_FFFF, 32'h0, 1);

    ram_chk_en = 1'b0;
    order_q.delete();
    fork
      begin
        cpu_go(4'b0000, 32'h3000_4028, 32'h0, 1'b0, 32'h0A0A_000A, 0);
        cpu_go(4'b0000, 32'h3000_4030, 32'h0, 1'b0, 32'h0C0C_000C, 0);
      end
      begin
        wb_go(1'b0, 4'hF, 32'h3000_402C, 32'h0, 32'h0B0B_000B, 0);
        wb_go(1'b0, 4'hF, 32'h3000_4034, 32'h0, 32'h0D0D_000D, 0);
      end
    join
    check_eq("grant_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < order_q.size()) check_eq("grant_order", 32'(order_q[i]), 32'(exp_order[i]));
    ram_chk_en = 1'b1;

    // Wishbone master drops cyc during ACCESS.
    ram_push(4, 1'b1, 4'b0000, 32'h0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_4010;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_eq("abort_access_csb", 32'(ram_csb0), 32'd0);
    #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n_ack = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) n_ack++;
    end
    check_eq("abort_no_ack", 32'(n_ack), 32'd0);
    @(posedge wb_clk_i); #1;
    ram_push(2, 1'b1, 4'b0000, 32'h0);
    cpu_go(4'b0000, 32'h3000_4008, 32'h0, 1'b0, 32'hAAAA_5678, 2);

    // Reset while the RAM is being accessed.
    ram_push(4, 1'b1, 4'b0000, 32'h0);
    cpu_stb = 1'b1; cpu_we = 4'b0000; cpu_addr = 32'h3000_4010;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_eq("rst_mid_access_csb", 32'(ram_csb0), 32'd0);
    #1;
    wb_rst_i = 1'b1; cpu_stb = 1'b0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_eq("rst_mid_csb", 32'(ram_csb0), 32'd1);
    check_eq("rst_mid_web", 32'(ram_web0), 32'd1);
    check_eq("rst_mid_ack", 32'(cpu_ack), 32'd0);
    #1;
    wb_rst_i = 1'b0;
    n_ack = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (cpu_ack || cpu_err) n_ack++;
    end
    check_eq("rst_mid_no_ack", 32'(n_ack), 32'd0);
    @(posedge wb_clk_i); #1;
    ram_push(11, 1'b1, 4'b0000, 32'h0);
    cpu_go(4'b0000, 32'h3000_402C, 32'h0, 1'b0, 32'h0B0B_000B, 2);

    repeat (2) @(posedge wb_clk_i);
    check_eq("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'd0);
    check_eq("wb_queue_drained", 32'(wb_exp_q.size()), 32'd0);
    check_eq("ram_queue_drained", 32'(ram_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
